// File: rtl/t03_alu_pkg.sv
// t03_alu_pkg: opcodes, FSM states and shared constants
// for the team_03 multi-cycle ALU.
package t03_alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'b00000,
    OP_SLL    = 5'b00001,
    OP_SLT    = 5'b00010,
    OP_SLTU   = 5'b00011,
    OP_XOR    = 5'b00100,
    OP_SRL    = 5'b00101,
    OP_OR     = 5'b00110,
    OP_AND    = 5'b00111,
    OP_SUB    = 5'b01000,
    OP_SRA    = 5'b01101,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } alu_state_t;

  // fill bit for unknown base opcodes
  localparam logic BASE_DFLT = 1'b0;

endpackage

// File: rtl/t03_mdu_iter.sv
// t03_mdu_iter: iterative shift-add multiply / restoring divide.
// Multiplier datapath present only with T03_ALU_MC_MUL_EN.
module t03_mdu_iter
  import t03_alu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            flush,
  input  logic            start,
  input  logic            is_div,
  input  logic            sel_hi,
  input  logic            neg,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] hi, lo, dvs;
  logic            busy, div_q, hsel_q, neg_q;
  logic [SHW-1:0]  cnt;

  logic [XLEN:0]   shl, diff;
  logic            take;
  logic [XLEN-1:0] dv_hi, dv_lo, pick, div_res;
  logic [XLEN-1:0] nxt_hi, nxt_lo;

  // hi = partial remainder, lo = dividend shifting into quotient
  assign shl     = {hi, lo[XLEN-1]};
  assign diff    = shl - {1'b0, dvs};
  assign take    = ~diff[XLEN];
  assign dv_hi   = take ? diff[XLEN-1:0] : shl[XLEN-1:0];
  assign dv_lo   = {lo[XLEN-2:0], take};
  assign pick    = hsel_q ? dv_hi : dv_lo;
  assign div_res = neg_q ? -pick : pick;

`ifdef T03_ALU_MC_MUL_EN
  logic [XLEN:0]     msum;
  logic [XLEN-1:0]   mu_hi, mu_lo, mul_res;
  logic [2*XLEN-1:0] prod, sprod;

  assign msum    = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
  assign mu_hi   = msum[XLEN:1];
  assign mu_lo   = {msum[0], lo[XLEN-1:1]};
  assign prod    = {mu_hi, mu_lo};
  assign sprod   = neg_q ? -prod : prod;
  assign mul_res = hsel_q ? sprod[2*XLEN-1:XLEN]
                          : sprod[XLEN-1:0];
  assign nxt_hi  = div_q ? dv_hi : mu_hi;
  assign nxt_lo  = div_q ? dv_lo : mu_lo;
  assign result  = div_q ? div_res : mul_res;
`else
  logic unused_div;
  assign unused_div = div_q;
  assign nxt_hi     = dv_hi;
  assign nxt_lo     = dv_lo;
  assign result     = div_res;
`endif

  assign done = busy & (cnt == SHW'(XLEN-1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hi     <= '0;
      lo     <= '0;
      dvs    <= '0;
      busy   <= 1'b0;
      div_q  <= 1'b0;
      hsel_q <= 1'b0;
      neg_q  <= 1'b0;
      cnt    <= '0;
    end else if (flush) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      hi     <= '0;
      lo     <= a;
      dvs    <= b;
      div_q  <= is_div;
      hsel_q <= sel_hi;
      neg_q  <= neg;
      busy   <= 1'b1;
      cnt    <= '0;
    end else if (busy) begin
      hi  <= nxt_hi;
      lo  <= nxt_lo;
      cnt <= done ? '0 : cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/t03_alu_mc.sv
// t03_alu_mc: multi-cycle RV32IM ALU with valid/ready handshake.
// Define T03_ALU_MC_MUL_EN to build the iterative multiplier.
module t03_alu_mc
  import t03_alu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic            alu_src,
  input  logic            auipc,
  input  logic            lui,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            negative,
  output logic            overflow
);

  localparam logic [XLEN-1:0] MIN_INT =
    {1'b1, {(XLEN-1){1'b0}}};

  alu_state_t      state;
  logic            accept;
  logic [XLEN-1:0] num1, num2;
  logic [XLEN:0]   add_w;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;
  logic            base_ovf;

  assign in_ready = (state == S_IDLE) |
                    ((state == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready & ~flush;

  assign num1  = auipc ? pc : (lui ? '0 : rd1);
  assign num2  = alu_src ? immediate : rd2;
  assign add_w = {1'b0, num1} + {1'b0, num2};
  assign shamt = num2[SHW-1:0];

  always_comb begin
    base_res = {XLEN{BASE_DFLT}};
    base_ovf = 1'b0;
    case (alu_op_t'(op))
      OP_ADD: begin
        base_res = add_w[XLEN-1:0];
        base_ovf = add_w[XLEN];
      end
      OP_SUB: begin
        base_res = num1 - num2;
        base_ovf = num1 < num2;
      end
      OP_XOR:  base_res = num1 ^ num2;
      OP_OR:   base_res = num1 | num2;
      OP_AND:  base_res = num1 & num2;
      OP_SLL:  base_res = num1 << shamt;
      OP_SRL:  base_res = num1 >> shamt;
      OP_SRA:  base_res = $signed(num1) >>> shamt;
      OP_SLT:  base_res = XLEN'($signed(num1) < $signed(num2));
      OP_SLTU: base_res = XLEN'(num1 < num2);
      default: ;
    endcase
  end

  logic [2:0]      fn;
  logic            s1, s2, hsel, is_div;
  logic            neg1, neg2, res_neg;
  logic [XLEN-1:0] mag1, mag2;
  logic            div0, dovf, mul_off;

  assign fn     = op[2:0];
  assign is_div = fn[2];

  // hsel: high product half for mul, remainder for div
  always_comb begin
    s1   = 1'b0;
    s2   = 1'b0;
    hsel = 1'b0;
    case (fn)
      3'b000:  begin s1 = 1'b1; s2 = 1'b1; end
      3'b001:  begin s1 = 1'b1; s2 = 1'b1; hsel = 1'b1; end
      3'b010:  begin s1 = 1'b1; hsel = 1'b1; end
      3'b011:  hsel = 1'b1;
      3'b100:  begin s1 = 1'b1; s2 = 1'b1; end
      3'b110:  begin s1 = 1'b1; s2 = 1'b1; hsel = 1'b1; end
      3'b111:  hsel = 1'b1;
      default: ;
    endcase
  end

  assign neg1    = s1 & num1[XLEN-1];
  assign neg2    = s2 & num2[XLEN-1];
  assign mag1    = neg1 ? -num1 : num1;
  assign mag2    = neg2 ? -num2 : num2;
  assign res_neg = (is_div & hsel) ? neg1 : (neg1 ^ neg2);
  assign div0    = is_div & (num2 == '0);
  assign dovf    = is_div & s1 & (num1 == MIN_INT) &
                   (num2 == '1);

`ifdef T03_ALU_MC_MUL_EN
  assign mul_off = 1'b0;
`else
  assign mul_off = ~is_div;
`endif

  logic            fast, fast_ovf;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    fast     = 1'b1;
    fast_res = base_res;
    fast_ovf = base_ovf;
    if (op[4]) begin
      fast     = 1'b0;
      fast_res = '0;
      fast_ovf = 1'b0;
      if (div0) begin
        fast     = 1'b1;
        fast_res = hsel ? num1 : '1;
        fast_ovf = 1'b1;
      end else if (dovf) begin
        fast     = 1'b1;
        fast_res = hsel ? '0 : MIN_INT;
        fast_ovf = 1'b1;
      end else if (mul_off) begin
        fast     = 1'b1;
        fast_ovf = 1'b1;
      end
    end
  end

  logic            mdu_done;
  logic [XLEN-1:0] mdu_res;

  t03_mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk    (clk),
    .nrst   (nrst),
    .flush  (flush),
    .start  (accept & ~fast),
    .is_div (is_div),
    .sel_hi (hsel),
    .neg    (res_neg),
    .a      (mag1),
    .b      (mag2),
    .done   (mdu_done),
    .result (mdu_res)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      result    <= '0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
          if (accept) begin
            if (fast) begin
              result    <= fast_res;
              zero      <= (fast_res == '0);
              negative  <= fast_res[XLEN-1];
              overflow  <= fast_ovf;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              out_valid <= 1'b0;
              state     <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (mdu_done) begin
            result    <= mdu_res;
            zero      <= (mdu_res == '0);
            negative  <= mdu_res[XLEN-1];
            overflow  <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t03_alu_mc.sv
// tb_t03_alu_mc: table-driven scoreboard bench for t03_alu_mc
// plus hand sequences for flush, reset and back-to-back.
module tb_t03_alu_mc;
  import t03_alu_pkg::*;

  localparam int XLEN = 32;
`ifdef T03_ALU_MC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [4:0]      op = '0;
  logic [XLEN-1:0] pc = '0, immediate = '0;
  logic [XLEN-1:0] rd1 = '0, rd2 = '0;
  logic            alu_src = 1'b0, auipc = 1'b0, lui = 1'b0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            zero, negative, overflow;

  always #5 clk = ~clk;

  t03_alu_mc #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .pc        (pc),
    .immediate (immediate),
    .rd1       (rd1),
    .rd2       (rd2),
    .alu_src   (alu_src),
    .auipc     (auipc),
    .lui       (lui),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] rd1, rd2, pc, imm;
    logic        src, au, lu;
    logic [31:0] res;
    logic        z, n, o;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        z, n, o;
    int          lat;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic addf(input logic [4:0] o_op,
                      input logic [31:0] a, b, p, im,
                      input logic s, au, lu,
                      input logic [31:0] res,
                      input logic ov, input int lat);
    vec_t v;
    v.op = o_op; v.rd1 = a; v.rd2 = b;
    v.pc = p; v.imm = im;
    v.src = s; v.au = au; v.lu = lu;
    v.res = res; v.z = (res == 0); v.n = res[31];
    v.o = ov; v.lat = lat;
    tv.push_back(v);
  endtask

  task automatic addr(input logic [4:0] o_op,
                      input logic [31:0] a, b, res,
                      input logic ov, input int lat);
    addf(o_op, a, b, 32'hDEAD0000, 32'h0BAD0000,
         1'b0, 1'b0, 1'b0, res, ov, lat);
  endtask

  // MUL-class: iterative when built in, else 1-cycle stub
  task automatic addm(input logic [4:0] o_op,
                      input logic [31:0] a, b, res);
    if (MUL_ON) addr(o_op, a, b, res, 1'b0, 33);
    else        addr(o_op, a, b, 32'h0, 1'b1, 1);
  endtask

  task automatic drive(input vec_t v);
    op = v.op; rd1 = v.rd1; rd2 = v.rd2;
    pc = v.pc; immediate = v.imm;
    alu_src = v.src; auipc = v.au; lui = v.lu;
  endtask

  task automatic scramble();
    op = 5'($urandom_range(0, 31));
    rd1 = $urandom(); rd2 = $urandom();
    pc = $urandom(); immediate = $urandom();
    alu_src = 1'($urandom_range(0, 1));
    auipc = 1'($urandom_range(0, 1));
    lui = 1'($urandom_range(0, 1));
  endtask

  task automatic apply(input vec_t v, input string nm);
    exp_t e;
    int   w, lat, busy;
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
    e.res = v.res; e.z = v.z; e.n = v.n;
    e.o = v.o; e.lat = v.lat;
    sb.push_back(e);
    lat = 1;
    busy = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (!in_ready) busy++;
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk({nm, " result"}, result, e.res);
    chk({nm, " zero"}, 32'(zero), 32'(e.z));
    chk({nm, " neg"}, 32'(negative), 32'(e.n));
    chk({nm, " ovf"}, 32'(overflow), 32'(e.o));
    chk({nm, " latency"}, lat, e.lat);
    chk({nm, " busy"}, busy, e.lat - 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic start_only(input vec_t v);
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic quiet(input string nm, input int n);
    int seen = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk(nm, seen, 0);
  endtask

  initial begin
    vec_t v;

    addr(OP_ADD,  32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1);
    addf(OP_ADD,  32'h5, 32'h7, 32'h1000, 32'h20,
         1'b1, 1'b1, 1'b0, 32'h1020, 1'b0, 1);
    addf(OP_ADD,  32'h5, 32'h7, 32'h1000, 32'h12345000,
         1'b1, 1'b0, 1'b1, 32'h12345000, 1'b0, 1);
    addf(OP_SUB,  32'h9, 32'h1, 32'h1000, 32'h20,
         1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1);
    addf(OP_ADD,  32'h5, 32'h7, 32'h100, 32'h0,
         1'b0, 1'b1, 1'b1, 32'h107, 1'b0, 1);
    addr(OP_SLT,  32'hFFFFFFFE, 32'h1, 32'h1, 1'b0, 1);
    addr(OP_SLTU, 32'hFFFFFFFE, 32'h1, 32'h0, 1'b0, 1);
    addr(OP_SRA,  32'h80000000, 32'h24, 32'hF8000000, 1'b0, 1);
    addr(OP_SUB,  32'h3, 32'h5, 32'hFFFFFFFE, 1'b1, 1);
    addr(OP_SUB,  32'h5, 32'h3, 32'h2, 1'b0, 1);
    addr(OP_SLL,  32'h1, 32'h21, 32'h2, 1'b0, 1);
    addr(OP_SRL,  32'h80000000, 32'h1F, 32'h1, 1'b0, 1);
    addr(OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00,
         32'h0FF00FF0, 1'b0, 1);
    addr(OP_OR,   32'h0F, 32'hF0, 32'hFF, 1'b0, 1);
    addr(OP_AND,  32'h0F, 32'hF0, 32'h0, 1'b0, 1);
    addr(5'b01001, 32'h5, 32'h6, 32'h0, 1'b0, 1);
    addm(OP_MULH,   32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF);
    addm(OP_MUL,    32'hFFFFFFFD, 32'h5, 32'hFFFFFFF1);
    addm(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    addm(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    addm(OP_MUL,    32'h6, 32'h7, 32'h2A);
    addm(OP_MULHU,  32'h6, 32'h7, 32'h0);
    addm(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000);
    addr(OP_DIV,  32'h7, 32'h0, 32'hFFFFFFFF, 1'b1, 1);
    addr(OP_DIV,  32'h80000000, 32'hFFFFFFFF,
         32'h80000000, 1'b1, 1);
    addr(OP_REM,  32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 1'b0, 33);
    addr(OP_DIVU, 32'd100, 32'd7, 32'hE, 1'b0, 33);
    addr(OP_DIV,  32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b0, 33);
    addr(OP_REMU, 32'd100, 32'd7, 32'h2, 1'b0, 33);
    addr(OP_DIV,  32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33);
    addr(OP_REM,  32'd7, 32'hFFFFFFFE, 32'h1, 1'b0, 33);
    addr(OP_DIVU, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 1'b0, 33);
    addr(OP_DIVU, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b1, 1);
    addr(OP_REM,  32'h7, 32'h0, 32'h7, 1'b1, 1);
    addr(OP_REMU, 32'h5, 32'h0, 32'h5, 1'b1, 1);

    repeat (2) @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst result", result, 0);
    chk("rst zero", 32'(zero), 0);
    chk("rst ovf", 32'(overflow), 0);
    nrst = 1'b1;
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 1);

    for (int i = 0; i < tv.size(); i++)
      apply(tv[i], $sformatf("v%0d", i));

    // async reset in the middle of a divide
    v = tv[0];
    v.op = OP_DIV; v.rd1 = 32'd1000; v.rd2 = 32'd3;
    v.res = 32'd333; v.z = 1'b0; v.n = 1'b0;
    v.o = 1'b0; v.lat = 33;
    start_only(v);
    repeat (10) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("mrst out_valid", 32'(out_valid), 0);
    chk("mrst result", result, 0);
    chk("mrst ovf", 32'(overflow), 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("mrst in_ready", 32'(in_ready), 1);
    quiet("mrst spurious", 40);

    // flush in the middle of a divide, then rerun it
    start_only(v);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("fl out_valid", 32'(out_valid), 0);
    chk("fl in_ready", 32'(in_ready), 1);
    quiet("fl spurious", 40);
    apply(v, "fl rerun");

    // request alongside flush must be dropped
    @(negedge clk);
    op = OP_ADD; rd1 = 32'h1; rd2 = 32'h1;
    alu_src = 1'b0; auipc = 1'b0; lui = 1'b0;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    quiet("fl drop", 3);

    // back-to-back accept from DONE
    @(negedge clk);
    op = OP_ADD; rd1 = 32'h2; rd2 = 32'h3;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b first valid", 32'(out_valid), 1);
    chk("b2b first res", result, 32'h5);
    op = OP_XOR; rd1 = 32'hA; rd2 = 32'h3;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("b2b in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b second valid", 32'(out_valid), 1);
    chk("b2b second res", result, 32'h9);
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("b2b drained", 32'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/t03_alu_mc.md
Name: t03_alu_mc

Overview:
- Parametrised multi-cycle ALU for the team_03 core.
- Executes the RV32I integer ops in one cycle and the RV32M multiply/divide ops iteratively.
- Uses a valid/ready handshake so the control unit can stall on long ops.
- Keeps the PC/immediate/LUI operand muxing at the front end; all results and flags are registered.

Parameters:
- XLEN, 32, datapath width in bits; must be a power of two ≥ 8.
- SHW, $clog2(XLEN), shift-amount width; derived, never overridden.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- op  in  5  operation code (encoding below)
- pc, immediate, rd1, rd2  in  XLEN each  operand sources
- alu_src, auipc, lui  in  1 each  operand-select controls
- flush  in  1  synchronous abort of any in-flight op
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- zero, negative, overflow  out  1 each  registered flags

Behaviour:
- Operand select, sampled on the accept edge (in_valid & in_ready):
  - num1 = auipc ? pc : lui ? 0 : rd1
  - num2 = alu_src ? immediate : rd2
  - Operands are latched internally; later input changes have no effect.
- Opcode encoding, op[4]=0 (base ops): ADD 0000, SUB 1000, XOR 0100, OR 0110, AND 0111, SLL 0001, SRL 0101, SRA 1101, SLT 0010, SLTU 0011. Any other base code gives result 0.
- Opcode encoding, op[4]=1 (M ops), op[2:0]: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
- Shifts use num2[SHW-1:0] only. SRA is arithmetic.
- SLT is a true signed compare; SLTU is unsigned. Both return 0 or 1.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. Accepting a base op computes and registers it, then goes to DONE. Accepting an M op loads the iteration registers, then goes to CALC.
  - CALC: in_ready=0. Performs one shift-add (mul) or restoring-subtract (div) step per cycle on operand magnitudes, with a 0..XLEN-1 counter. After XLEN steps, signs are fixed and the result registered; go to DONE.
  - DONE: out_valid=1 and result/flags are held. On out_ready, in_ready=1; a new request accepted in the same cycle is legal (back-to-back). Go to IDLE, or load the new op.
- Latency, counted from the accept edge to out_valid high:
  - base ops: 1 cycle
  - M ops: XLEN+1 cycles (33 cycles at XLEN=32)
  - divide by zero: 1 cycle, fast path
- Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = num1.
- Signed overflow (DIV of min-int by -1): quotient = min-int, remainder = 0, 1-cycle fast path.
- Flags, registered with result:
  - zero = (result==0); negative = result[XLEN-1].
  - overflow = carry-out for ADD, unsigned borrow for SUB, 1 for divide-by-zero or signed DIV overflow, 0 otherwise.
- flush: highest priority after reset. Forces IDLE next cycle with out_valid=0 from any state; a request presented in the same cycle is not accepted.
- Reset: nrst low at any time (including mid-CALC) asynchronously gives state=IDLE, result=0, zero=0, negative=0, overflow=0, out_valid=0, counter=0. in_ready is 1 once nrst is released.

Optional Feature:
- Macro: T03_ALU_MC_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU are implemented as above.
- Undefined: the multiplier datapath is omitted. MUL-class ops complete in 1 cycle with result=0 and overflow=1; DIV/REM behaviour is unchanged.

Decomposition:
- Package t03_alu_pkg holds:
  - typedef enum logic [4:0] alu_op_t, all 18 codes
  - typedef enum logic [1:0] alu_state_t
  - localparam for the base-op default result
- Sub-module t03_mdu_iter: the iterative mul/div engine. It takes a start pulse plus magnitudes and sign info, and returns done, result and flag inputs. t03_alu_mc owns the FSM, operand muxing and base ops.

Test Plan (XLEN=32):
- ADD rd1=0xFFFFFFFF, rd2=1 -> one cycle later out_valid, result=0, zero=1, overflow=1.
- auipc=1, alu_src=1, pc=0x1000, imm=0x20, ADD -> result=0x1020.
- SLT rd1=0xFFFFFFFE (-2), rd2=1 -> result=1. SLTU with the same operands -> result=0.
- SRA rd1=0x80000000, rd2=0x24 (shamt 4) -> result=0xF8000000, negative=1.
- MULH rd1=-3, rd2=5 -> in_ready low for 32 CALC cycles, out_valid at cycle 33, result=0xFFFFFFFF. MUL with the same operands -> 0xFFFFFFF1. Without T03_ALU_MC_MUL_EN: result=0, overflow=1 after 1 cycle.
- Divide and abort cases:
  - DIV 7 / 0 -> result=0xFFFFFFFF, overflow=1, 1-cycle latency.
  - DIV 0x80000000 / -1 -> result=0x80000000, overflow=1.
  - REM -7 / 2 -> result=0xFFFFFFFF.
  - nrst or flush asserted mid-CALC -> IDLE, out_valid=0, no spurious result.
